// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-port, variable-latency memory bus between the instruction
//   fetch port and the MEM-stage data port. Data accesses take priority over
//   fetches. Bus outputs are registered and held until ack. A flushed fetch is
//   drained silently. A bus cycle that never acks is aborted with a bus_err pulse.
//
// Ports
//   clk, resetn                  clock; synchronous active-high reset
//   if_req/if_addr               fetch request (held until if_ready)
//   if_rdata/if_ready            fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata    data request from MEM (held until d_ready)
//   d_rdata/d_ready              load data (0 for stores) and completion pulse
//   flush                        exception flush; drops an in-flight fetch
//   stall_req                    combinational stall to the pipeline controller
//   bus_req/we/addr/wdata        registered bus cycle outputs
//   bus_ack/bus_rdata            bus completion and read data
//   bus_err                      one-cycle pulse on timeout abort
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  input  logic        flush,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_WAIT  = 2'd1,
    I_WAIT  = 2'd2,
    I_DRAIN = 2'd3
  } state_t;

  localparam bit             TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic               if_ready_q, if_ready_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               d_ready_q, d_ready_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_hit;

  // The counter holds the number of completed wait cycles; this cycle is the
  // last one allowed when it already holds TIMEOUT_CYCLES-1. An ack in the same
  // cycle takes precedence over the abort.
  assign timeout_hit = TIMEOUT_EN && !bus_ack && (cnt_q == TIMEOUT_LAST);

  // Ready is registered, so a requester is still stalled in the cycle before
  // its pulse and released in the pulse cycle itself.
  assign stall_req = (d_req & ~d_ready_q) | (if_req & ~if_ready_q);

  // Next-state and registered-output logic. Ready and error are pulses, so
  // they default low every cycle; everything else holds unless updated.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_ready_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_ready_d   = 1'b0;
    bus_err_d   = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        // A request seen in a ready cycle is treated as a new request, which
        // lets back-to-back accesses complete every two cycles.
        if (d_req) begin
          bus_req_d   = 1'b1;
          bus_we_d    = d_we;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
          cnt_d       = '0;
          state_d     = D_WAIT;
        end else if (if_req && !flush) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          cnt_d       = '0;
          state_d     = I_WAIT;
        end
      end

      D_WAIT: begin
        // Flush is ignored here: an accepted store must reach memory.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          d_rdata_d = bus_we_q ? 32'h0 : bus_rdata;
          d_ready_d = 1'b1;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          d_rdata_d = 32'h0;
          d_ready_d = 1'b1;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      I_WAIT: begin
        // A flush coinciding with completion also discards the fetched word.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!flush) begin
            if_rdata_d = bus_rdata;
            if_ready_d = 1'b1;
          end
          state_d = IDLE;
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!flush) begin
            if_rdata_d = 32'h0;
            if_ready_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (flush) begin
            state_d = I_DRAIN;
          end
        end
      end

      I_DRAIN: begin
        // The bus cannot abort a cycle, so wait it out and drop the result.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        bus_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      d_rdata_q   <= d_rdata_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign bus_err   = bus_err_q;

endmodule
